// File: rtl/pc_fetch_ctrl.sv
// ----------------------------------------------------------------------------
// pc_fetch_ctrl
//   Program-counter register and next-PC selection for the single-cycle
//   datapath. It holds the architectural fetch PC, and steps it sequentially
//   or redirects it to a branch/jump target. While instruction memory reports
//   BUSYWAIT the PC freezes. A redirect that arrives during that stall is
//   buffered and applied when the stall ends.
//
// Parameters
//   RESET_PC      PC value loaded on reset
//   PC_STEP       sequential increment in bytes
//
// Ports
//   CLK           in   1   clock, rising edge
//   RESET         in   1   asynchronous active-low reset
//   BUSYWAIT      in   1   instruction memory not ready, hold PC
//   BRANCH_TAKEN  in   1   beq resolved taken this cycle
//   JUMP          in   1   j instruction this cycle
//   TARGET        in   32  branch/jump target address
//   PC            out  32  current fetch address (registered)
//   PC_NEXT       out  32  value PC takes at next edge if BUSYWAIT=0
//   FETCH_VALID   out  1   PC is a live fetch address
//   REDIR_PEND    out  1   a buffered redirect is waiting
//   MISALIGN      out  1   one-cycle pulse, loaded target had raw [1:0]!=0
//   REDIR_COUNT   out  16  saturating count of applied redirects
//
// Build option
//   PC_REDIR_COUNT_EN  when defined, REDIR_COUNT is a live saturating
//                      counter. Otherwise REDIR_COUNT is tied to zero and no
//                      counter flops exist.
// ----------------------------------------------------------------------------
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          PC_STEP  = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        BUSYWAIT,
    input  logic        BRANCH_TAKEN,
    input  logic        JUMP,
    input  logic [31:0] TARGET,
    output logic [31:0] PC,
    output logic [31:0] PC_NEXT,
    output logic        FETCH_VALID,
    output logic        REDIR_PEND,
    output logic        MISALIGN,
    output logic [15:0] REDIR_COUNT
);

    localparam logic [1:0] ST_BOOT   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_STALL  = 2'd2;
    localparam logic [1:0] ST_STALLR = 2'd3;

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_held;
    logic        r_held_mis;   // raw low bits of the buffered target were nonzero
    logic        r_pend;
    logic        r_fetch_valid;
    logic        r_misalign;

    logic        w_redir;
    logic        w_tgt_mis;
    logic [31:0] w_tgt;
    logic [31:0] w_seq;
    logic [31:0] w_pc_next;
    logic        w_advance;    // PC updates at this edge
    logic        w_load_redir; // PC loads from TARGET or from the buffer
    logic        w_next_mis;
    logic [1:0]  w_state_nxt;

    always_comb begin
        w_redir   = BRANCH_TAKEN | JUMP;
        w_tgt     = {TARGET[31:2], 2'b00};
        w_tgt_mis = |TARGET[1:0];
        w_seq     = r_pc + 32'(PC_STEP);   // wraps modulo 2^32

        // Live redirect beats a buffered one, and a buffered one beats sequential.
        w_pc_next    = w_seq;
        w_load_redir = 1'b0;
        w_next_mis   = 1'b0;
        if (r_state == ST_BOOT) begin
            w_pc_next = r_pc;
        end else if (w_redir) begin
            w_pc_next    = w_tgt;
            w_load_redir = 1'b1;
            w_next_mis   = w_tgt_mis;
        end else if (r_pend) begin
            w_pc_next    = r_held;
            w_load_redir = 1'b1;
            w_next_mis   = r_held_mis;
        end

        w_advance = (r_state != ST_BOOT) && !BUSYWAIT;

        w_state_nxt = r_state;
        if (r_state == ST_BOOT) begin
            w_state_nxt = ST_RUN;
        end else if (!BUSYWAIT) begin
            w_state_nxt = ST_RUN;
        end else if (r_pend || w_redir) begin
            w_state_nxt = ST_STALLR;
        end else begin
            w_state_nxt = ST_STALL;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state       <= ST_BOOT;
            r_pc          <= RESET_PC;
            r_held        <= 32'h0000_0000;
            r_held_mis    <= 1'b0;
            r_pend        <= 1'b0;
            r_fetch_valid <= 1'b0;
            r_misalign    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_misalign <= 1'b0;
            if (r_state == ST_BOOT) begin
                r_fetch_valid <= 1'b1;
            end else if (BUSYWAIT) begin
                // A stalled redirect is buffered. A newer one overwrites it.
                if (w_redir) begin
                    r_held     <= w_tgt;
                    r_held_mis <= w_tgt_mis;
                    r_pend     <= 1'b1;
                end
            end else begin
                r_pc       <= w_pc_next;
                r_pend     <= 1'b0;
                r_misalign <= w_next_mis;
            end
        end
    end

`ifdef PC_REDIR_COUNT_EN
    logic [15:0] r_redir_cnt;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_redir_cnt <= 16'h0000;
        end else if (w_advance && w_load_redir && (r_redir_cnt != 16'hFFFF)) begin
            r_redir_cnt <= r_redir_cnt + 16'h0001;
        end
    end

    assign REDIR_COUNT = r_redir_cnt;
`else
    logic w_unused_cnt;
    assign w_unused_cnt = w_advance & w_load_redir;
    assign REDIR_COUNT  = 16'h0000;
`endif

    assign PC          = r_pc;
    assign PC_NEXT     = w_pc_next;
    assign FETCH_VALID = r_fetch_valid;
    assign REDIR_PEND  = r_pend;
    assign MISALIGN    = r_misalign;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
module tb_pc_fetch_ctrl;

    logic        CLK;
    logic        RESET;
    logic        BUSYWAIT;
    logic        BRANCH_TAKEN;
    logic        JUMP;
    logic [31:0] TARGET;
    logic [31:0] PC;
    logic [31:0] PC_NEXT;
    logic        FETCH_VALID;
    logic        REDIR_PEND;
    logic        MISALIGN;
    logic [15:0] REDIR_COUNT;

    pc_fetch_ctrl dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .BUSYWAIT     (BUSYWAIT),
        .BRANCH_TAKEN (BRANCH_TAKEN),
        .JUMP         (JUMP),
        .TARGET       (TARGET),
        .PC           (PC),
        .PC_NEXT      (PC_NEXT),
        .FETCH_VALID  (FETCH_VALID),
        .REDIR_PEND   (REDIR_PEND),
        .MISALIGN     (MISALIGN),
        .REDIR_COUNT  (REDIR_COUNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: architectural view (live flag, pending buffer, counter).
    logic [31:0] m_pc;
    logic        m_live;
    logic        m_pend;
    logic [31:0] m_held;
    logic        m_held_mis;
    logic        m_mis;
    int          m_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] exp_count();
`ifdef PC_REDIR_COUNT_EN
        return (m_cnt > 65535) ? 16'hFFFF : 16'(m_cnt);
`else
        return 16'h0000;
`endif
    endfunction

    task automatic model_reset();
        m_pc = 32'h0; m_live = 0; m_pend = 0; m_held = 32'h0;
        m_held_mis = 0; m_mis = 0; m_cnt = 0;
    endtask

    task automatic check_regs(input string tag);
        chk({tag, ".pc"},   PC,          m_pc);
        chk({tag, ".fv"},   FETCH_VALID, 32'(m_live));
        chk({tag, ".pend"}, REDIR_PEND,  32'(m_pend));
        chk({tag, ".mis"},  MISALIGN,    32'(m_mis));
        chk({tag, ".cnt"},  REDIR_COUNT, 32'(exp_count()));
    endtask

    // One clock cycle: drive inputs, check the combinational next PC, take the
    // edge, advance the model, and check the registered outputs.
    task automatic step(input logic busy, input logic br, input logic jp,
                        input logic [31:0] tgt, input string tag);
        logic        redir;
        logic [31:0] atgt;
        logic [31:0] exp_next;
        BUSYWAIT = busy; BRANCH_TAKEN = br; JUMP = jp; TARGET = tgt;
        redir = br | jp;
        atgt  = tgt & 32'hFFFF_FFFC;
        #1;
        if (m_live) begin
            if (redir)       exp_next = atgt;
            else if (m_pend) exp_next = m_held;
            else             exp_next = m_pc + 32'd4;
            chk({tag, ".pcnext"}, PC_NEXT, exp_next);
        end
        @(posedge CLK);
        if (!m_live) begin
            m_live = 1; m_mis = 0;
        end else if (busy) begin
            m_mis = 0;
            if (redir) begin
                m_pend = 1; m_held = atgt; m_held_mis = (tgt[1:0] != 2'b00);
            end
        end else begin
            if (redir) begin
                m_pc = atgt; m_mis = (tgt[1:0] != 2'b00); m_cnt++;
            end else if (m_pend) begin
                m_pc = m_held; m_mis = m_held_mis; m_cnt++;
            end else begin
                m_pc = m_pc + 32'd4; m_mis = 0;
            end
            m_pend = 0;
        end
        #1;
        check_regs(tag);
    endtask

    task automatic do_reset();
        BUSYWAIT = 0; BRANCH_TAKEN = 0; JUMP = 0; TARGET = 32'h0;
        RESET = 1'b0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        check_regs("reset");
        @(negedge CLK);
        RESET = 1'b1;
    endtask

    initial begin
        RESET = 1'b1;
        #2;
        do_reset();

        // Boot, then sequential stepping.
        step(0, 0, 0, 32'h0, "boot");
        chk("boot.pc_hold", PC, 32'h0);
        step(0, 0, 0, 32'h0, "seq1");
        chk("seq1.pc4", PC, 32'h4);
        step(0, 0, 0, 32'h0, "seq2");
        chk("seq2.pc8", PC, 32'h8);

        // Taken branch.
        step(0, 1, 0, 32'h40, "br");
        chk("br.pc40", PC, 32'h40);
        step(0, 0, 0, 32'h0, "br_seq");
        chk("br_seq.pc44", PC, 32'h44);

        // Redirect during a stall.
        step(0, 0, 1, 32'h10, "to10");
        step(1, 0, 1, 32'h80, "st1");
        step(1, 0, 0, 32'h0,  "st2");
        step(1, 0, 0, 32'h0,  "st3");
        chk("st3.hold10", PC, 32'h10);
        chk("st3.pend", REDIR_PEND, 32'h1);
        step(0, 0, 0, 32'h0, "st_rel");
        chk("st_rel.pc80", PC, 32'h80);
        chk("st_rel.pend0", REDIR_PEND, 32'h0);

        // Newest buffered redirect wins, live redirect beats buffer.
        step(1, 1, 0, 32'h300, "nw1");
        step(1, 0, 1, 32'h400, "nw2");
        step(0, 0, 0, 32'h0,   "nw3");
        chk("nw3.pc400", PC, 32'h400);
        step(1, 1, 0, 32'h500, "lv1");
        step(0, 1, 1, 32'h600, "lv2");
        chk("lv2.pc600", PC, 32'h600);

        // Wrap and misalignment.
        step(0, 0, 1, 32'hFFFF_FFFC, "wr1");
        step(0, 0, 0, 32'h0, "wr2");
        chk("wr2.pc0", PC, 32'h0);
        step(0, 0, 1, 32'h103, "mis1");
        chk("mis1.pc100", PC, 32'h100);
        chk("mis1.pulse", MISALIGN, 32'h1);
        step(0, 0, 0, 32'h0, "mis2");
        chk("mis2.clear", MISALIGN, 32'h0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            logic busy, br, jp;
            logic [31:0] t;
            busy = ($urandom_range(0, 9) < 4);
            br   = ($urandom_range(0, 9) < 2);
            jp   = ($urandom_range(0, 9) < 2);
            t    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : $urandom;
            step(busy, br, jp, t, "rnd");
        end

        // Asynchronous reset while a redirect is pending.
        step(1, 0, 1, 32'h200, "ar1");
        chk("ar1.pend", REDIR_PEND, 32'h1);
        #2;
        RESET = 1'b0;
        #1;
        chk("ar.pc",   PC,          32'h0);
        chk("ar.pend", REDIR_PEND,  32'h0);
        chk("ar.fv",   FETCH_VALID, 32'h0);
        chk("ar.cnt",  REDIR_COUNT, 32'h0);
        model_reset();
        @(negedge CLK);
        RESET = 1'b1;
        step(0, 0, 0, 32'h0, "ar_boot");
        step(0, 0, 0, 32'h0, "ar_seq");
        chk("ar_seq.pc4", PC, 32'h4);

        // Three redirects on a clean counter.
        step(0, 1, 0, 32'h20, "c1");
        step(1, 0, 1, 32'h30, "c2a");
        step(0, 0, 0, 32'h0,  "c2b");
        step(0, 1, 1, 32'h50, "c3");
`ifdef PC_REDIR_COUNT_EN
        chk("cnt.three", REDIR_COUNT, 32'd3);
`else
        chk("cnt.zero", REDIR_COUNT, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
